// File: rtl/mem_access_ctrl.sv
// MEM-stage initiator for the DataMemory port.
// Takes one load/store at a time over a valid/ready handshake, issues a
// registered Mem_Write_Read/word_byte command, waits READ_LAT cycles on
// loads, extends byte loads and returns the result over a response
// handshake. `stall` freezes earlier pipeline stages while busy.
//
// Handshake rules: a transfer happens on a rising clk edge where both
// valid and ready are 1. req_ready is 1 only in IDLE. resp_valid stays 1
// with resp_data/resp_err stable until resp_ready is seen. The controller
// never drops a response once it has raised resp_valid.
module mem_access_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_word,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              stall,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] write_data,
    output logic [1:0]        Mem_Write_Read,
    output logic              word_byte,
    input  logic [DATA_W-1:0] Read_data
);

    localparam int CNT_W = (READ_LAT < 2) ? 1 : $clog2(READ_LAT + 1);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b01;
    localparam logic [1:0] CMD_READ  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // Current state is kept as a named signal so it can be probed directly.
    state_t state, state_n;

    logic [ADDR_W-1:0] addr_q,  addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [1:0]        cmd_q,   cmd_n;
    logic              wb_q,    wb_n;
    logic              sgn_q,   sgn_n;
    logic [DATA_W-1:0] rdata_q, rdata_n;
    logic              err_q,   err_n;
    logic [CNT_W-1:0]  cnt_q,   cnt_n;

    logic [DATA_W-1:0] byte_ext;

    // Byte load result: extend the low byte of the returned word.
    always_comb begin
        byte_ext = '0;
        if (sgn_q) begin
            byte_ext = {{(DATA_W-8){Read_data[7]}}, Read_data[7:0]};
        end else begin
            byte_ext = {{(DATA_W-8){1'b0}}, Read_data[7:0]};
        end
    end

    // Next-state and next-value logic for all registered outputs.
    always_comb begin
        state_n = state;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        cmd_n   = cmd_q;
        wb_n    = wb_q;
        sgn_n   = sgn_q;
        rdata_n = rdata_q;
        err_n   = err_q;
        cnt_n   = cnt_q;

        case (state)
            S_IDLE: begin
                cmd_n = CMD_IDLE;
                if (req_valid) begin
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    wb_n    = req_word;
                    sgn_n   = req_signed;
                    if (req_word && (req_addr[1:0] != 2'b00)) begin
                        // Misaligned word: answer with an error, touch no memory.
                        state_n = S_RESP;
                        err_n   = 1'b1;
                        rdata_n = '0;
                    end else if (req_write) begin
                        state_n = S_WR;
                        cmd_n   = CMD_WRITE;
                    end else begin
                        state_n = S_RD;
                        cmd_n   = CMD_READ;
                        cnt_n   = CNT_W'(READ_LAT);
                    end
                end
            end
            S_WR: begin
                // Write command lives exactly one cycle.
                state_n = S_RESP;
                cmd_n   = CMD_IDLE;
                rdata_n = '0;
                err_n   = 1'b0;
            end
            S_RD: begin
                cnt_n = cnt_q - CNT_W'(1);
                if (cnt_n == '0) begin
                    state_n = S_RESP;
                    cmd_n   = CMD_IDLE;
                    err_n   = 1'b0;
                    rdata_n = wb_q ? Read_data : byte_ext;
                end
            end
            S_RESP: begin
                cmd_n = CMD_IDLE;
                if (resp_ready) begin
                    state_n = S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                cmd_n   = CMD_IDLE;
            end
        endcase
    end

    // State and registered command/response outputs; reset aborts any access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            cmd_q   <= CMD_IDLE;
            wb_q    <= 1'b0;
            sgn_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            cmd_q   <= cmd_n;
            wb_q    <= wb_n;
            sgn_q   <= sgn_n;
            rdata_q <= rdata_n;
            err_q   <= err_n;
            cnt_q   <= cnt_n;
        end
    end

    assign req_ready      = (state == S_IDLE);
    assign resp_valid     = (state == S_RESP);
    assign stall          = (state == S_WR) || (state == S_RD) ||
                            ((state == S_RESP) && !resp_ready);
    assign resp_data      = rdata_q;
    assign resp_err       = err_q;
    assign Address        = addr_q;
    assign write_data     = wdata_q;
    assign Mem_Write_Read = cmd_q;
    assign word_byte      = wb_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: one instance with READ_LAT=1 backed by
// a small byte-addressed memory model, and one with READ_LAT=3 backed by an
// address-derived read pattern for the latency check.
module tb_mem_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid, req_write, req_word, req_signed;
    logic [31:0] req_addr, req_wdata;
    logic        resp_ready;
    logic        req_ready, resp_valid, resp_err, stall, word_byte;
    logic [31:0] resp_data, Address, write_data, Read_data;
    logic [1:0]  Mem_Write_Read;

    logic        req_valid3, resp_ready3;
    logic        req_ready3, resp_valid3, resp_err3, stall3, word_byte3;
    logic [31:0] resp_data3, Address3, write_data3, Read_data3;
    logic [1:0]  Mem_Write_Read3;

    int n_checks;
    int n_errors;

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .READ_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_word(req_word), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err), .stall(stall),
        .Address(Address), .write_data(write_data),
        .Mem_Write_Read(Mem_Write_Read), .word_byte(word_byte),
        .Read_data(Read_data)
    );

    mem_access_ctrl #(.ADDR_W(32), .DATA_W(32), .READ_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write), .req_word(req_word), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid3), .resp_ready(resp_ready3),
        .resp_data(resp_data3), .resp_err(resp_err3), .stall(stall3),
        .Address(Address3), .write_data(write_data3),
        .Mem_Write_Read(Mem_Write_Read3), .word_byte(word_byte3),
        .Read_data(Read_data3)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-addressed memory model (little-endian) for the READ_LAT=1 instance.
    logic [7:0] mem [0:63];
    logic [5:0] ma;
    assign ma = Address[5:0];

    always @(posedge clk) begin
        if (Mem_Write_Read == 2'b01) begin
            mem[ma] <= write_data[7:0];
            if (word_byte) begin
                mem[ma + 6'd1] <= write_data[15:8];
                mem[ma + 6'd2] <= write_data[23:16];
                mem[ma + 6'd3] <= write_data[31:24];
            end
        end
    end

    // Byte reads carry junk in the upper bits so extension must ignore them.
    always_comb begin
        Read_data = 32'h0;
        if (word_byte) begin
            Read_data = {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};
        end else begin
            Read_data = {24'h123456, mem[ma]};
        end
    end

    assign Read_data3 = {16'hCAFE, Address3[15:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request to the READ_LAT=1 instance for a single edge.
    task automatic send(input logic w, input logic wd, input logic sg,
                        input logic [31:0] a, input logic [31:0] d);
        req_write  = w;
        req_word   = wd;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = d;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_word    = 1'b0;
        req_signed  = 1'b0;
        req_addr    = 32'h0;
        req_wdata   = 32'h0;
        resp_ready  = 1'b1;
        req_valid3  = 1'b0;
        resp_ready3 = 1'b1;

        // Reset values.
        #12;
        chk("rst_req_ready",  {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_data",  resp_data, 32'h0);
        chk("rst_resp_err",   {31'h0, resp_err}, 32'h0);
        chk("rst_stall",      {31'h0, stall}, 32'h0);
        chk("rst_address",    Address, 32'h0);
        chk("rst_wdata",      write_data, 32'h0);
        chk("rst_cmd",        {30'h0, Mem_Write_Read}, 32'h0);
        chk("rst_word_byte",  {31'h0, word_byte}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Word store 100 at addr 4 with a delayed response accept.
        resp_ready = 1'b0;
        send(1'b1, 1'b1, 1'b0, 32'd4, 32'd100);
        chk("st_cmd",       {30'h0, Mem_Write_Read}, 32'h1);
        chk("st_addr",      Address, 32'd4);
        chk("st_wdata",     write_data, 32'd100);
        chk("st_word_byte", {31'h0, word_byte}, 32'h1);
        chk("st_stall",     {31'h0, stall}, 32'h1);
        chk("st_req_ready", {31'h0, req_ready}, 32'h0);
        tick();
        chk("st_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("st_resp_err",   {31'h0, resp_err}, 32'h0);
        chk("st_resp_data",  resp_data, 32'h0);
        chk("st_cmd_done",   {30'h0, Mem_Write_Read}, 32'h0);
        chk("st_resp_stall", {31'h0, stall}, 32'h1);
        resp_ready = 1'b1;
        #1;
        chk("st_stall_rr", {31'h0, stall}, 32'h0);
        tick();
        chk("st_idle_valid", {31'h0, resp_valid}, 32'h0);
        chk("st_idle_ready", {31'h0, req_ready}, 32'h1);

        // Word load from addr 4, READ_LAT=1.
        send(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
        chk("ld_cmd",        {30'h0, Mem_Write_Read}, 32'h2);
        chk("ld_addr",       Address, 32'd4);
        chk("ld_word_byte",  {31'h0, word_byte}, 32'h1);
        chk("ld_early_valid", {31'h0, resp_valid}, 32'h0);
        tick();
        chk("ld_resp_valid", {31'h0, resp_valid}, 32'h1);
        chk("ld_resp_data",  resp_data, 32'd100);
        chk("ld_cmd_done",   {30'h0, Mem_Write_Read}, 32'h0);
        tick();

        // Byte store 0x85 at addr 3, then signed and unsigned byte loads.
        send(1'b1, 1'b0, 1'b0, 32'd3, 32'hAAAAAA85);
        chk("bst_cmd",       {30'h0, Mem_Write_Read}, 32'h1);
        chk("bst_addr",      Address, 32'd3);
        chk("bst_word_byte", {31'h0, word_byte}, 32'h0);
        tick();
        tick();
        send(1'b0, 1'b0, 1'b1, 32'd3, 32'd0);
        chk("bls_word_byte", {31'h0, word_byte}, 32'h0);
        chk("bls_cmd",       {30'h0, Mem_Write_Read}, 32'h2);
        tick();
        chk("bls_data",      resp_data, 32'hFFFFFF85);
        tick();
        send(1'b0, 1'b0, 1'b0, 32'd3, 32'd0);
        chk("blu_word_byte", {31'h0, word_byte}, 32'h0);
        tick();
        chk("blu_data",      resp_data, 32'h00000085);
        tick();

        // Misaligned word load: immediate error, no memory command.
        send(1'b0, 1'b1, 1'b0, 32'd3, 32'd0);
        chk("mis_valid", {31'h0, resp_valid}, 32'h1);
        chk("mis_err",   {31'h0, resp_err}, 32'h1);
        chk("mis_data",  resp_data, 32'h0);
        chk("mis_cmd",   {30'h0, Mem_Write_Read}, 32'h0);
        tick();
        chk("mis_cmd_idle", {30'h0, Mem_Write_Read}, 32'h0);

        // Backpressure on a load of 100 from addr 4; a new request waits.
        resp_ready = 1'b0;
        send(1'b0, 1'b1, 1'b0, 32'd4, 32'd0);
        tick();
        req_write  = 1'b1;
        req_word   = 1'b1;
        req_addr   = 32'd12;
        req_wdata  = 32'd7;
        req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {31'h0, resp_valid}, 32'h1);
            chk("bp_data",  resp_data, 32'd100);
            chk("bp_stall", {31'h0, stall}, 32'h1);
            chk("bp_ready", {31'h0, req_ready}, 32'h0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("bp_idle_ready", {31'h0, req_ready}, 32'h1);
        chk("bp_not_taken",  {30'h0, Mem_Write_Read}, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("bp_taken_cmd",  {30'h0, Mem_Write_Read}, 32'h1);
        chk("bp_taken_addr", Address, 32'd12);
        tick();
        tick();

        // Store at the top of the address space; response accepted on arrival.
        send(1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'd55);
        chk("top_addr", Address, 32'hFFFFFFFC);
        chk("top_cmd",  {30'h0, Mem_Write_Read}, 32'h1);
        tick();
        chk("top_valid", {31'h0, resp_valid}, 32'h1);
        chk("top_stall", {31'h0, stall}, 32'h0);
        tick();
        chk("top_idle_valid", {31'h0, resp_valid}, 32'h0);
        chk("top_idle_ready", {31'h0, req_ready}, 32'h1);

        // Reset in the middle of a read.
        send(1'b0, 1'b1, 1'b0, 32'd8, 32'd0);
        chk("mr_cmd_rd", {30'h0, Mem_Write_Read}, 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_cmd",   {30'h0, Mem_Write_Read}, 32'h0);
        chk("mr_valid", {31'h0, resp_valid}, 32'h0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("mr_ready_after", {31'h0, req_ready}, 32'h1);
        chk("mr_valid_after", {31'h0, resp_valid}, 32'h0);
        chk("mr_cmd_after",   {30'h0, Mem_Write_Read}, 32'h0);

        // READ_LAT=3 instance: word load at addr 0.
        req_write  = 1'b0;
        req_word   = 1'b1;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_valid3 = 1'b1;
        tick();
        req_valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("lat3_cmd",   {30'h0, Mem_Write_Read3}, 32'h2);
            chk("lat3_addr",  Address3, 32'd0);
            chk("lat3_early", {31'h0, resp_valid3}, 32'h0);
            tick();
        end
        chk("lat3_valid",    {31'h0, resp_valid3}, 32'h1);
        chk("lat3_data",     resp_data3, 32'hCAFE0000);
        chk("lat3_cmd_done", {30'h0, Mem_Write_Read3}, 32'h0);
        tick();
        chk("lat3_idle", {31'h0, req_ready3}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
